// File: rtl/spi_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the spi_controller slave port.
// Define SPI_ARB_TIMEOUT_EN to build the stalled-transfer watchdog.
module spi_wb_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat_o,
    output logic [DATA_W-1:0] m0_dat_i,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat_o,
    output logic [DATA_W-1:0] m1_dat_i,
    output logic              m1_ack,
    output logic              m1_err,

    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack,
    input  logic              s_err,

    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   tmo;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
        $error("spi_wb_arbiter: TIMEOUT must lie in 2..65535");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // On a tie the master that was not served last wins.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc && (!m1_cyc || last_q)) begin
                    state_d = StOwn0;
                    last_d  = 1'b0;
                end else if (m1_cyc) begin
                    state_d = StOwn1;
                    last_d  = 1'b1;
                end
            end
            StOwn0:  if (!m0_cyc) state_d = StIdle;
            StOwn1:  if (!m1_cyc) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant    = state_q;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_o  = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_dat_i = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_dat_i = '0;
        unique case (state_q)
            StOwn0: begin
                s_cyc    = m0_cyc & ~tmo;
                s_stb    = m0_stb & ~tmo;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_o  = m0_dat_o;
                m0_ack   = s_ack & ~tmo;
                m0_err   = s_err | tmo;
                m0_dat_i = s_dat_i;
            end
            StOwn1: begin
                s_cyc    = m1_cyc & ~tmo;
                s_stb    = m1_stb & ~tmo;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_o  = m1_dat_o;
                m1_ack   = s_ack & ~tmo;
                m1_err   = s_err | tmo;
                m1_dat_i = s_dat_i;
            end
            default: ;
        endcase
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        own_stb;

    assign own_stb = (state_q == StOwn0) ? m0_stb :
                     (state_q == StOwn1) ? m1_stb : 1'b0;
    assign tmo     = own_stb && (wd_q == 16'(TIMEOUT - 1));

    // Counts only cycles where the owner is waiting on a stalled slave.
    always_comb begin
        if ((state_d != state_q) || tmo || !own_stb || s_ack || s_err) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// Scoreboard bench for spi_wb_arbiter with a registered-ack memory slave behind it.
module tb_spi_wb_arbiter;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [31:0] rdat[2];
    logic        ack [2];
    logic        err [2];

    logic        s_cyc, s_stb, s_we, s_ack, s_err;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [1:0]  grant;

    logic        stall;
    logic        ack_r;
    logic [31:0] mem [256];

    exp_t        q0[$];
    exp_t        q1[$];
    int          total = 0;
    int          bad   = 0;

    logic        watch  = 1'b0;
    logic        bwatch = 1'b0;
    int          bviol  = 0;
    logic [1:0]  glog[$];

    spi_wb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(cyc[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_adr(adr[0]),
        .m0_dat_o(dat[0]), .m0_dat_i(rdat[0]), .m0_ack(ack[0]), .m0_err(err[0]),
        .m1_cyc(cyc[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_adr(adr[1]),
        .m1_dat_o(dat[1]), .m1_dat_i(rdat[1]), .m1_ack(ack[1]), .m1_err(err[1]),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err),
        .grant(grant)
    );

    initial forever #5 clk = ~clk;

    // Slave model: acks one cycle after seeing a strobe, unless stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= s_cyc && s_stb && !ack_r && !stall;
            if (s_cyc && s_stb && s_we && !ack_r && !stall) mem[s_adr[7:0]] <= s_dat_o;
        end
    end
    assign s_ack   = ack_r;
    assign s_err   = 1'b0;
    assign s_dat_i = mem[s_adr[7:0]];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic mon(input int m);
        exp_t e;
        if ((m == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL m%0d_unexpected: ack=%b err=%b want no response", m, ack[m], err[m]);
            return;
        end
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("m%0d_ack", m), 32'(ack[m]), 32'(!e.err));
        chk($sformatf("m%0d_err", m), 32'(err[m]), 32'(e.err));
        if (e.rd) chk($sformatf("m%0d_rdata", m), rdat[m], e.data);
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (ack[0] || err[0]) mon(0);
            if (ack[1] || err[1]) mon(1);
        end
    end

    initial forever begin
        @(negedge clk);
        if (watch) glog.push_back(grant);
        if (bwatch && (grant !== 2'b10 || s_adr === 32'h01)) bviol++;
    end

    // Called right after a rising edge; returns right after a rising edge.
    task automatic xfer(input int m, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic last);
        logic seen = 1'b0;
        exp_t e;
        e = '{rd: !w, data: d, err: 1'b0};
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
        cyc[m] = 1'b1;
        stb[m] = 1'b1;
        we[m]  = w;
        adr[m] = {24'h0, a};
        dat[m] = w ? d : 32'h0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = ack[m] || err[m];
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL m%0d_xfer_timeout: got no ack want ack", m);
        end
        @(posedge clk); #1;
        stb[m] = 1'b0;
        we[m]  = 1'b0;
        if (last) begin
            cyc[m] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] vals[$];
        int         lens[$];
        logic [1:0] exp_vals[6];
        int         exp_lens[6];
        logic       m0done;
        int         errk, errn;
        logic       stbk;

        for (int m = 0; m < 2; m++) begin
            cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0; adr[m] = '0; dat[m] = '0;
        end
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_s_stb", 32'(s_stb), 32'h0);
        chk("rst_s_adr", s_adr, 32'h0);
        chk("rst_m0_ack", 32'(ack[0]), 32'h0);
        chk("rst_m1_err", 32'(err[1]), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a stalled m0 transfer.
        stall = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h40;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pre_stb", 32'(s_stb), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_s_cyc", 32'(s_cyc), 32'h0);
        chk("midrst_grant", 32'(grant), 32'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Tie after reset: owners must run m0, m1, m0 with one idle cycle between.
        glog.delete();
        watch = 1'b1;
        fork
            begin
                xfer(0, 1'b1, 8'h01, 32'h11, 1'b1);
                xfer(0, 1'b1, 8'h02, 32'h12, 1'b1);
            end
            xfer(1, 1'b1, 8'h03, 32'h21, 1'b1);
        join
        watch = 1'b0;
        foreach (glog[i]) begin
            if (i == 0 || glog[i] !== glog[i-1]) begin
                vals.push_back(glog[i]);
                lens.push_back(1);
            end else begin
                lens[lens.size()-1]++;
            end
        end
        exp_vals = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        exp_lens = '{1, 3, 1, 3, 1, 3};
        chk("tie_runs", 32'(vals.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < vals.size()) begin
                chk($sformatf("tie_grant%0d", i), 32'(vals[i]), 32'(exp_vals[i]));
                chk($sformatf("tie_len%0d", i), 32'(lens[i]), 32'(exp_lens[i]));
            end
        end
        @(posedge clk); #1;

        // Single master write with m1 idle.
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h0; dat[0] = 32'h5A;
        q0.push_back('{rd: 1'b0, data: 32'h0, err: 1'b0});
        @(negedge clk);
        chk("single_grant_req", 32'(grant), 32'h0);
        @(negedge clk);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_s_dat_o", s_dat_o, 32'h5A);
        chk("single_s_stb", 32'(s_stb), 32'h1);
        @(negedge clk);
        chk("single_s_ack", 32'(s_ack), 32'h1);
        chk("single_m0_ack", 32'(ack[0]), 32'h1);
        chk("single_m1_ack", 32'(ack[1]), 32'h0);
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Burst lock: m1 writes 8 beats while m0 waits on a read of 0x01.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h80; dat[1] = 32'h0;
        @(posedge clk); #1;
        bwatch = 1'b1;
        m0done = 1'b0;
        fork
            begin
                xfer(0, 1'b0, 8'h01, 32'h11, 1'b1);
                m0done = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) xfer(1, 1'b1, 8'(8'h80 + i), 32'(i), 1'b0);
        cyc[1] = 1'b0;
        @(negedge clk);
        chk("burst_drop_grant", 32'(grant), 32'h2);
        bwatch = 1'b0;
        @(negedge clk);
        chk("burst_idle", 32'(grant), 32'h0);
        @(negedge clk);
        chk("burst_m0_grant", 32'(grant), 32'h1);
        chk("burst_viol", 32'(bviol), 32'h0);
        for (int n = 0; n < 50 && !m0done; n++) @(posedge clk);
        chk("burst_m0_done", 32'(m0done), 32'h1);
        @(posedge clk); #1;
        xfer(1, 1'b0, 8'h83, 32'h3, 1'b1);

        // Watchdog on a slave that never acks.
        stall = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h05;
`ifdef SPI_ARB_TIMEOUT_EN
        q0.push_back('{rd: 1'b0, data: 32'h0, err: 1'b1});
        @(negedge clk);
        errk = -1;
        stbk = 1'b1;
        for (int k = 0; k < 40 && errk < 0; k++) begin
            @(negedge clk);
            if (err[0]) begin
                errk = k;
                stbk = s_stb;
            end
        end
        chk("tmo_err_cycle", 32'(errk), 32'd15);
        chk("tmo_s_stb", 32'(stbk), 32'h0);
`else
        errn = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (err[0]) errn++;
        end
        chk("no_tmo_err", 32'(errn), 32'h0);
`endif
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Interleaved write/read-back from both masters.
        fork
            for (int i = 0; i < 255; i++) begin
                xfer(0, 1'b1, 8'h10, 32'(i), 1'b1);
                xfer(0, 1'b0, 8'h10, 32'(i), 1'b1);
            end
            for (int j = 0; j < 255; j++) begin
                xfer(1, 1'b1, 8'h20, 32'(j), 1'b1);
                xfer(1, 1'b0, 8'h20, 32'(j), 1'b1);
            end
        join

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_wb_arbiter.md
# spi_wb_arbiter

Two-master Wishbone arbiter that shares the single slave port of `spi_controller` between two requesters, e.g. the CPU data bus and a boot or DMA engine. Round-robin grant; ownership held for the whole Wishbone cycle (CYC high), so multi-byte SPI bursts are never interleaved. An optional watchdog terminates a stalled transfer with ERR.

## Interface
Parameters:
- `ADDR_W`, default 32: Wishbone address width.
- `DATA_W`, default 32: Wishbone data width.
- `TIMEOUT`, default 1024: watchdog limit in cycles, range 2..65535. Used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; every register is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_cyc`, `m0_stb`, `m0_we` in 1 each: master 0 request signals.
- `m0_adr` in `ADDR_W`: master 0 address.
- `m0_dat_o` in `DATA_W`: master 0 write data.
- `m0_dat_i` out `DATA_W`: master 0 read data.
- `m0_ack`, `m0_err` out 1 each: master 0 termination.
- `m1_*`: identical set for master 1.
- `s_cyc`, `s_stb`, `s_we` out 1 each: to the `spi_controller` Wishbone port.
- `s_adr` out `ADDR_W`: to the `spi_controller` Wishbone port.
- `s_dat_o` out `DATA_W`: to the `spi_controller` Wishbone port.
- `s_dat_i` in `DATA_W`: from the controller.
- `s_ack`, `s_err` in 1 each: from the controller.
- `grant` out 2: one-hot current owner. `2'b00` means idle.

## Operation
- State machine states: IDLE, OWN0, OWN1. State is held in registers. `grant` is taken straight from the state.
- `last` register: identifies the master served most recently. Reset value is 1, so master 0 wins the first tie.
- From IDLE:
  - Only `m0_cyc` high: go to OWN0.
  - Only `m1_cyc` high: go to OWN1.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
- On entering OWNx, `last` takes the value x.
- From OWNx, owner's `mx_cyc` low: go to IDLE. Otherwise stay in OWNx. A master holding CYC high can never be preempted.
- Slave outputs are combinational from the registered state:
  - OWNx: `s_*` is a copy of `mx_*`.
  - IDLE: `s_cyc`, `s_stb`, `s_we` = 0; `s_adr` and `s_dat_o` = 0.
- Return path:
  - Owner: `mx_ack` = `s_ack`, `mx_err` = `s_err`, `mx_dat_i` = `s_dat_i`.
  - Non-owner: ack and err = 0, `dat_i` = 0.
- A master asserting STB without ownership simply waits. Its request is never dropped.
- Reset values: state IDLE, `grant` 0, every ack/err output 0, every `s_*` output 0, `last` 1, watchdog count 0.
- Reset asserted mid-transfer: the state machine goes to IDLE at once, without waiting for a clock edge. `s_cyc` drops in the same instant. A pending ACK is lost, and the master must retry.

## Timing
- Grant latency: a request made in IDLE is registered on the next rising edge. `s_stb` goes high in that following cycle, so arbitration costs 1 cycle.
- Data-path latency after grant: 0 cycles. ACK, ERR and `dat_i` pass through combinationally in the cycle the slave drives them.
- Release: owner drops CYC in cycle n. State is IDLE in cycle n+1. The earliest new grant is in cycle n+2, giving exactly one idle bus cycle between owners.
- Simultaneous events:
  - Owner drops CYC while the other master requests: the handover follows the release timing above.
  - Both masters request in the same IDLE cycle: the round-robin rule decides.

## Configuration
- Macro `SPI_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter increments each cycle in which the owner has STB high and neither `s_ack` nor `s_err` is high.
  - The counter clears on ACK, on ERR, on STB low, and on any change of state.
  - When the count equals `TIMEOUT`-1, the arbiter drives the owner's err high for one cycle, with ack 0. In that cycle `s_cyc` and `s_stb` are forced low, and the counter clears.
  - The owner keeps ownership until it drops CYC.
- Undefined:
  - No counter is built.
  - A stalled slave holds the bus indefinitely.
  - `TIMEOUT` is ignored.

## Test plan
- Single master: m0 writes 0x5A to address 0 while m1 is idle.
  - `grant` = 01 one cycle after the request.
  - `s_dat_o` = 0x5A.
  - `m0_ack` pulses in the same cycle as `s_ack`.
  - m1 never sees an ack.
- Tie, then alternation: both masters raise CYC in the same cycle, three times in a row.
  - Grant order is m0, m1, m0.
  - Exactly one `grant` = 00 cycle separates each pair of owners.
- Burst lock: m1 holds CYC for 8 back-to-back writes of 0x00..0x07 while m0 requests continuously.
  - `grant` stays 10 for the whole burst and `s_adr` never shows m0's address.
  - m0 is granted 2 cycles after m1 drops CYC.
- Reset mid-transfer: assert `rst` while in OWN0 with `s_stb` high and no ack yet.
  - `s_cyc` = 0 and `grant` = 00 before the next clock edge.
  - After release, a tie grants m0.
- Timeout, with the macro defined and `TIMEOUT`=16: the slave never acks a read from m0.
  - `m0_err` pulses exactly 15 cycles after `s_stb` first rises.
  - `s_stb` is 0 in that cycle.
  - With the macro undefined, no err appears in 2000 cycles.
- Loopback: run a controller with MISO tied to MOSI behind the arbiter. m0 and m1 each write and read back 0x00..0xFE, interleaved.
  - Every read returns the value its own master wrote.
  - Every transfer ends with ack and no err.
